alu_arb: RTL and testbench

ALU_ARB -- requirements
Module: alu_arb

---
 rtl/alu_arb_pkg.sv | 13 +
 rtl/alu_arb_alu.sv | 44 ++++
 rtl/alu_arb.sv | 134 +++++++++++++
 tb/tb_alu_arb.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the alu_arb controller and its ALU.
package alu_arb_pkg;
  localparam int NREQ = 2;

  localparam logic [6:0] R_TYPE    = 7'b0110011;
  localparam logic [6:0] I_TYPE_OP = 7'b0010011;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;
endpackage

// File: rtl/alu_arb_alu.sv
// Combinational RV32I integer ALU for OP and OP-IMM instructions.
module alu_arb_alu
  import alu_arb_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [DATA_W-1:0] rs1,
  input  logic [DATA_W-1:0] rs2,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] result,
  output logic              err
);
  localparam int SH_W = $clog2(DATA_W);

  logic              is_r;
  logic              alt;
  logic [DATA_W-1:0] b;
  logic [SH_W-1:0]   sh;

  always_comb begin
    is_r   = (opcode == R_TYPE);
    err    = !is_r && (opcode != I_TYPE_OP);
    b      = is_r ? rs2 : imm;
    alt    = (funct7 == 7'b0100000);
    sh     = b[SH_W-1:0];
    result = '0;
    // SUB exists only in R-type; OP-IMM with funct3=0 is always ADDI.
    case (funct3)
      3'd0: result = (is_r && alt) ? rs1 - b : rs1 + b;
      3'd1: result = rs1 << sh;
      3'd2: result = {{(DATA_W-1){1'b0}}, $signed(rs1) < $signed(b)};
      3'd3: result = {{(DATA_W-1){1'b0}}, rs1 < b};
      3'd4: result = rs1 ^ b;
      3'd5: result = alt ? DATA_W'($signed(rs1) >>> sh) : rs1 >> sh;
      3'd6: result = rs1 | b;
      3'd7: result = rs1 & b;
      default: result = '0;
    endcase
    if (err) result = '0;
  end
endmodule

// File: rtl/alu_arb.sv
// Two-requester arbiter around one shared ALU, one transaction in flight.
// Define ALU_ARB_RR_EN for round-robin arbitration; default is fixed priority.
module alu_arb #(
  parameter int DATA_W = 32,
  parameter int NREQ   = alu_arb_pkg::NREQ
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic              req0_valid_in,
  output logic              req0_ready_out,
  input  logic [6:0]        req0_opcode_in,
  input  logic [2:0]        req0_funct3_in,
  input  logic [6:0]        req0_funct7_in,
  input  logic [DATA_W-1:0] req0_rs1_in,
  input  logic [DATA_W-1:0] req0_rs2_in,
  input  logic [DATA_W-1:0] req0_imm_in,
  input  logic              req1_valid_in,
  output logic              req1_ready_out,
  input  logic [6:0]        req1_opcode_in,
  input  logic [2:0]        req1_funct3_in,
  input  logic [6:0]        req1_funct7_in,
  input  logic [DATA_W-1:0] req1_rs1_in,
  input  logic [DATA_W-1:0] req1_rs2_in,
  input  logic [DATA_W-1:0] req1_imm_in,
  output logic              rsp0_valid_out,
  input  logic              rsp0_ready_in,
  output logic              rsp1_valid_out,
  input  logic              rsp1_ready_in,
  output logic [DATA_W-1:0] rsp_result_out,
  output logic              rsp_non_zero_out,
  output logic              rsp_err_out
);
  import alu_arb_pkg::*;

  localparam int GW = $clog2(NREQ);

  state_t            state_q, state_d;
  logic [GW-1:0]     grant, grant_q;
  logic              idle_ok;
  logic              handshake;
  logic              rsp_ready_sel;
  logic              sel0;
  logic [6:0]        opcode_q;
  logic [2:0]        funct3_q;
  logic [6:0]        funct7_q;
  logic [DATA_W-1:0] rs1_q, rs2_q, imm_q;
  logic [DATA_W-1:0] alu_result;
  logic              alu_err;

`ifdef ALU_ARB_RR_EN
  logic [GW-1:0] rr_q;

  always_comb begin
    if (req0_valid_in && req1_valid_in) grant = rr_q;
    else                                grant = req1_valid_in ? GW'(1) : GW'(0);
  end

  // Pointer names the requester that wins the next tie; reset favours req0.
  always_ff @(posedge clk_in) begin
    if (reset_in)       rr_q <= '0;
    else if (handshake) rr_q <= ~grant;
  end
`else
  always_comb begin
    grant = req0_valid_in ? GW'(0) : GW'(1);
  end
`endif

  always_comb begin
    idle_ok        = (state_q == IDLE) && !reset_in;
    req0_ready_out = idle_ok && req0_valid_in && (grant == GW'(0));
    req1_ready_out = idle_ok && req1_valid_in && (grant == GW'(1));
    handshake      = req0_ready_out || req1_ready_out;
    sel0           = (grant == GW'(0));
  end

  always_comb begin
    state_d        = state_q;
    rsp_ready_sel  = (grant_q == GW'(0)) ? rsp0_ready_in : rsp1_ready_in;
    rsp0_valid_out = (state_q == RESP) && (grant_q == GW'(0));
    rsp1_valid_out = (state_q == RESP) && (grant_q == GW'(1));
    case (state_q)
      IDLE:    if (handshake) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready_sel) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q          <= IDLE;
      grant_q          <= '0;
      opcode_q         <= '0;
      funct3_q         <= '0;
      funct7_q         <= '0;
      rs1_q            <= '0;
      rs2_q            <= '0;
      imm_q            <= '0;
      rsp_result_out   <= '0;
      rsp_non_zero_out <= 1'b0;
      rsp_err_out      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (handshake) begin
        grant_q  <= grant;
        opcode_q <= sel0 ? req0_opcode_in : req1_opcode_in;
        funct3_q <= sel0 ? req0_funct3_in : req1_funct3_in;
        funct7_q <= sel0 ? req0_funct7_in : req1_funct7_in;
        rs1_q    <= sel0 ? req0_rs1_in    : req1_rs1_in;
        rs2_q    <= sel0 ? req0_rs2_in    : req1_rs2_in;
        imm_q    <= sel0 ? req0_imm_in    : req1_imm_in;
      end
      if (state_q == EXEC) begin
        rsp_result_out   <= alu_result;
        rsp_non_zero_out <= |alu_result;
        rsp_err_out      <= alu_err;
      end
    end
  end

  alu_arb_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .opcode (opcode_q),
    .funct3 (funct3_q),
    .funct7 (funct7_q),
    .rs1    (rs1_q),
    .rs2    (rs2_q),
    .imm    (imm_q),
    .result (alu_result),
    .err    (alu_err)
  );
endmodule

// File: tb/tb_alu_arb.sv
// Scoreboard bench for alu_arb: expectations queued at issue, checked on response.
module tb_alu_arb;
  logic        clk_in = 1'b0;
  logic        reset_in;
  logic        req0_valid_in, req0_ready_out;
  logic [6:0]  req0_opcode_in;
  logic [2:0]  req0_funct3_in;
  logic [6:0]  req0_funct7_in;
  logic [31:0] req0_rs1_in, req0_rs2_in, req0_imm_in;
  logic        req1_valid_in, req1_ready_out;
  logic [6:0]  req1_opcode_in;
  logic [2:0]  req1_funct3_in;
  logic [6:0]  req1_funct7_in;
  logic [31:0] req1_rs1_in, req1_rs2_in, req1_imm_in;
  logic        rsp0_valid_out, rsp0_ready_in;
  logic        rsp1_valid_out, rsp1_ready_in;
  logic [31:0] rsp_result_out;
  logic        rsp_non_zero_out, rsp_err_out;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_BR  = 7'b1100011;

  typedef struct {
    int          port;
    logic [31:0] res;
    logic        nz;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk_in = ~clk_in;

  alu_arb #(.DATA_W(32), .NREQ(2)) dut (
    .clk_in           (clk_in),
    .reset_in         (reset_in),
    .req0_valid_in    (req0_valid_in),
    .req0_ready_out   (req0_ready_out),
    .req0_opcode_in   (req0_opcode_in),
    .req0_funct3_in   (req0_funct3_in),
    .req0_funct7_in   (req0_funct7_in),
    .req0_rs1_in      (req0_rs1_in),
    .req0_rs2_in      (req0_rs2_in),
    .req0_imm_in      (req0_imm_in),
    .req1_valid_in    (req1_valid_in),
    .req1_ready_out   (req1_ready_out),
    .req1_opcode_in   (req1_opcode_in),
    .req1_funct3_in   (req1_funct3_in),
    .req1_funct7_in   (req1_funct7_in),
    .req1_rs1_in      (req1_rs1_in),
    .req1_rs2_in      (req1_rs2_in),
    .req1_imm_in      (req1_imm_in),
    .rsp0_valid_out   (rsp0_valid_out),
    .rsp0_ready_in    (rsp0_ready_in),
    .rsp1_valid_out   (rsp1_valid_out),
    .rsp1_ready_in    (rsp1_ready_in),
    .rsp_result_out   (rsp_result_out),
    .rsp_non_zero_out (rsp_non_zero_out),
    .rsp_err_out      (rsp_err_out)
  );

  function automatic exp_t mk(input int p, input logic [31:0] r, input logic n, input logic e);
    exp_t x;
    x.port = p; x.res = r; x.nz = n; x.err = e;
    return x;
  endfunction

  // Reference RV32I behaviour for OP / OP-IMM.
  function automatic exp_t model(input int p, input logic [6:0] op, input logic [2:0] f3,
                                 input logic [6:0] f7, input logic [31:0] a,
                                 input logic [31:0] r2, input logic [31:0] imm);
    logic [31:0] b, y;
    int          sh;
    b  = (op == OP_R) ? r2 : imm;
    sh = int'(b[4:0]);
    y  = 32'd0;
    case (f3)
      3'd0: y = (op == OP_R && f7 == 7'h20) ? a - b : a + b;
      3'd1: y = a << sh;
      3'd2: y = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: y = (a < b) ? 32'd1 : 32'd0;
      3'd4: y = a ^ b;
      3'd5: y = (f7 == 7'h20) ? 32'($signed(a) >>> sh) : a >> sh;
      3'd6: y = a | b;
      default: y = a & b;
    endcase
    if (op != OP_R && op != OP_I) return mk(p, 32'd0, 1'b0, 1'b1);
    return mk(p, y, y != 32'd0, 1'b0);
  endfunction

  task automatic drive_req(input int p, input logic [6:0] op, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] imm);
    if (p == 0) begin
      req0_valid_in = 1'b1; req0_opcode_in = op; req0_funct3_in = f3; req0_funct7_in = f7;
      req0_rs1_in = a; req0_rs2_in = b; req0_imm_in = imm;
    end else begin
      req1_valid_in = 1'b1; req1_opcode_in = op; req1_funct3_in = f3; req1_funct7_in = f7;
      req1_rs1_in = a; req1_rs2_in = b; req1_imm_in = imm;
    end
  endtask

  task automatic drop_req(input int p);
    if (p == 0) req0_valid_in = 1'b0;
    else        req1_valid_in = 1'b0;
  endtask

  // Called #1 after a rising edge with the DUT idle; returns #1 into the EXEC cycle.
  task automatic issue(input int p, input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] imm);
    logic rdy;
    drive_req(p, op, f3, f7, a, b, imm);
    @(negedge clk_in);
    rdy = (p == 0) ? req0_ready_out : req1_ready_out;
    total++;
    if (rdy !== 1'b1) begin
      bad++;
      $display("FAIL issue_ready%0d: got %b want 1", p, rdy);
    end
    @(posedge clk_in); #1;
    drop_req(p);
  endtask

  // Waits for the response on port p, checks it against the queue head, consumes it.
  task automatic collect(input int p, input int want_lat);
    int   lat;
    logic seen, other;
    exp_t e;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      @(negedge clk_in);
      lat++;
      seen = (p == 0) ? rsp0_valid_out : rsp1_valid_out;
    end
    total++;
    if (seen !== 1'b1) begin
      bad++;
      $display("FAIL rsp%0d_timeout: no valid within %0d cycles", p, lat);
      return;
    end
    if (want_lat > 0) begin
      total++;
      if (lat != want_lat) begin
        bad++;
        $display("FAIL rsp%0d_latency: got %0d want %0d", p, lat, want_lat);
      end
    end
    other = (p == 0) ? rsp1_valid_out : rsp0_valid_out;
    total++;
    if (other !== 1'b0) begin
      bad++;
      $display("FAIL rsp%0d_other_valid: got %b want 0", p, other);
    end
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL rsp%0d_unexpected: response with empty scoreboard", p);
    end else begin
      e = sb.pop_front();
      if (e.port != p) begin
        bad++;
        $display("FAIL rsp_port: got %0d want %0d", p, e.port);
      end
      total++;
      if (rsp_result_out !== e.res) begin
        bad++;
        $display("FAIL rsp%0d_result: got %h want %h", p, rsp_result_out, e.res);
      end
      total++;
      if (rsp_non_zero_out !== e.nz) begin
        bad++;
        $display("FAIL rsp%0d_non_zero: got %b want %b", p, rsp_non_zero_out, e.nz);
      end
      total++;
      if (rsp_err_out !== e.err) begin
        bad++;
        $display("FAIL rsp%0d_err: got %b want %b", p, rsp_err_out, e.err);
      end
    end
    if (p == 0) rsp0_ready_in = 1'b1; else rsp1_ready_in = 1'b1;
    @(posedge clk_in); #1;
    rsp0_ready_in = 1'b0;
    rsp1_ready_in = 1'b0;
  endtask

  task automatic test_reset;
    reset_in = 1'b1;
    req0_valid_in = 1'b1;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    total++;
    if ({req0_ready_out, req1_ready_out, rsp0_valid_out, rsp1_valid_out} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_handshake: got %b want 0000",
               {req0_ready_out, req1_ready_out, rsp0_valid_out, rsp1_valid_out});
    end
    total++;
    if ({rsp_result_out, rsp_non_zero_out, rsp_err_out} !== 34'd0) begin
      bad++;
      $display("FAIL reset_rsp: got %h/%b/%b want 0/0/0", rsp_result_out, rsp_non_zero_out, rsp_err_out);
    end
    req0_valid_in = 1'b0;
    @(posedge clk_in); #1;
    reset_in = 1'b0;
  endtask

  task automatic test_add;
    sb.push_back(mk(0, 32'd12, 1'b1, 1'b0));
    issue(0, OP_R, 3'd0, 7'h00, 32'd5, 32'd7, 32'd0);
    collect(0, 2);
  endtask

  task automatic test_err;
    sb.push_back(mk(0, 32'd0, 1'b0, 1'b1));
    issue(0, OP_LD, 3'd2, 7'h00, 32'h1234, 32'h55, 32'd4);
    collect(0, 2);
  endtask

  task automatic test_xori;
    sb.push_back(mk(1, 32'd0, 1'b0, 1'b0));
    issue(1, OP_I, 3'd4, 7'h00, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF);
    collect(1, 2);
  endtask

  task automatic test_stall;
    sb.push_back(mk(0, 32'h0000_00FF, 1'b1, 1'b0));
    issue(0, OP_R, 3'd6, 7'h00, 32'hF0, 32'h0F, 32'd0);
    drive_req(1, OP_R, 3'd0, 7'h00, 32'd1, 32'd1, 32'd0);
    rsp1_ready_in = 1'b1;
    @(negedge clk_in);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_in);
      total++;
      if ({rsp0_valid_out, rsp1_valid_out, req1_ready_out} !== 3'b100) begin
        bad++;
        $display("FAIL stall_flags%0d: got %b want 100", i,
                 {rsp0_valid_out, rsp1_valid_out, req1_ready_out});
      end
      total++;
      if (rsp_result_out !== 32'h0000_00FF) begin
        bad++;
        $display("FAIL stall_result%0d: got %h want 000000ff", i, rsp_result_out);
      end
      if (i == 3) begin
        drop_req(1);
        rsp1_ready_in = 1'b0;
      end
    end
    collect(0, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      total++;
      if (rsp1_valid_out !== 1'b0) begin
        bad++;
        $display("FAIL dropped_valid%0d: got %b want 0", i, rsp1_valid_out);
      end
    end
    @(posedge clk_in); #1;
  endtask

  task automatic test_arb;
    drive_req(0, OP_R, 3'd0, 7'h00, 32'd1, 32'd2, 32'd0);
    drive_req(1, OP_R, 3'd0, 7'h20, 32'd10, 32'd3, 32'd0);
    @(negedge clk_in);
    total++;
    if ({req0_ready_out, req1_ready_out} !== 2'b10) begin
      bad++;
      $display("FAIL arb_first: got %b want 10", {req0_ready_out, req1_ready_out});
    end
    sb.push_back(mk(0, 32'd3, 1'b1, 1'b0));
    @(posedge clk_in); #1;
    collect(0, 2);
    @(negedge clk_in);
`ifdef ALU_ARB_RR_EN
    total++;
    if ({req0_ready_out, req1_ready_out} !== 2'b01) begin
      bad++;
      $display("FAIL arb_rr_second: got %b want 01", {req0_ready_out, req1_ready_out});
    end
    sb.push_back(mk(1, 32'd7, 1'b1, 1'b0));
    @(posedge clk_in); #1;
    drop_req(0);
    drop_req(1);
    collect(1, 2);
`else
    total++;
    if ({req0_ready_out, req1_ready_out} !== 2'b10) begin
      bad++;
      $display("FAIL arb_prio_second: got %b want 10", {req0_ready_out, req1_ready_out});
    end
    sb.push_back(mk(0, 32'd3, 1'b1, 1'b0));
    @(posedge clk_in); #1;
    drop_req(0);
    collect(0, 2);
    @(negedge clk_in);
    total++;
    if (req1_ready_out !== 1'b1) begin
      bad++;
      $display("FAIL arb_req1_alone: got %b want 1", req1_ready_out);
    end
    sb.push_back(mk(1, 32'd7, 1'b1, 1'b0));
    @(posedge clk_in); #1;
    drop_req(1);
    collect(1, 2);
`endif
  endtask

  task automatic test_reset_exec;
    issue(0, OP_R, 3'd0, 7'h00, 32'd100, 32'd200, 32'd0);
    reset_in = 1'b1;
    @(posedge clk_in); #1;
    reset_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_in);
      total++;
      if ({rsp0_valid_out, rsp1_valid_out} !== 2'b00 || rsp_result_out !== 32'd0) begin
        bad++;
        $display("FAIL reset_exec_drop%0d: got valid=%b result=%h want 00/0", i,
                 {rsp0_valid_out, rsp1_valid_out}, rsp_result_out);
      end
    end
    @(posedge clk_in); #1;
    drive_req(1, OP_R, 3'd7, 7'h00, 32'hFF, 32'h0F, 32'd0);
    drive_req(0, OP_R, 3'd0, 7'h00, 32'd20, 32'd22, 32'd0);
    @(negedge clk_in);
    total++;
    if ({req0_ready_out, req1_ready_out} !== 2'b10) begin
      bad++;
      $display("FAIL reset_exec_favour0: got %b want 10", {req0_ready_out, req1_ready_out});
    end
    sb.push_back(mk(0, 32'd42, 1'b1, 1'b0));
    @(posedge clk_in); #1;
    drop_req(0);
    drop_req(1);
    collect(0, 2);
  endtask

  task automatic test_mix;
    int          p, sel;
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    logic [31:0] a, b, imm;
    for (int i = 0; i < 12; i++) begin
      p   = int'($urandom_range(0, 1));
      sel = int'($urandom_range(0, 4));
      op  = (sel < 2) ? OP_R : (sel < 4) ? OP_I : OP_BR;
      f3  = 3'($urandom_range(0, 7));
      f7  = ($urandom_range(0, 1) == 0) ? 7'h00 : 7'h20;
      a   = $urandom;
      b   = $urandom;
      imm = $urandom;
      if (i == 0) b = a;
      sb.push_back(model(p, op, f3, f7, a, b, imm));
      issue(p, op, f3, f7, a, b, imm);
      collect(p, 2);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_in = 1'b1;
    req0_valid_in = 1'b0; req0_opcode_in = '0; req0_funct3_in = '0; req0_funct7_in = '0;
    req0_rs1_in = '0; req0_rs2_in = '0; req0_imm_in = '0;
    req1_valid_in = 1'b0; req1_opcode_in = '0; req1_funct3_in = '0; req1_funct7_in = '0;
    req1_rs1_in = '0; req1_rs2_in = '0; req1_imm_in = '0;
    rsp0_ready_in = 1'b0;
    rsp1_ready_in = 1'b0;
    test_reset;
    test_add;
    test_err;
    test_xori;
    test_stall;
    test_arb;
    test_reset_exec;
    test_mix;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
